// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - piece/state enums, board geometry and 4x4 rotation map table
package tetris_pkg;

  typedef enum logic [2:0] {
    P_I = 3'd0, P_O = 3'd1, P_T = 3'd2, P_S = 3'd3, P_Z = 3'd4, P_J = 3'd5, P_L = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    S_SPAWN, S_FALL, S_DROP, S_LOCK, S_SETTLE, S_OVER
  } state_t;

  localparam int BOARD_W = 10;
  localparam int WALL_L  = 0;
  localparam int WALL_R  = BOARD_W + 1;

  // Row 7 is a blank guard entry so any 3-bit type code indexes safely.
  localparam logic [15:0] ROT_MAP [0:7][0:3] = '{
    '{16'h00F0, 16'h2222, 16'h0F00, 16'h4444},
    '{16'h6600, 16'h6600, 16'h6600, 16'h6600},
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80},
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000}
  };

  function automatic piece_t next_piece(input piece_t p);
    return (p == P_L) ? P_I : piece_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/tetris_piece_rom.sv
// rtl/tetris_piece_rom.sv - combinational (piece type, rotation) to 16-bit occupancy map
module tetris_piece_rom
  import tetris_pkg::*;
(
  input  logic [2:0]  ptype,
  input  logic [1:0]  rot,
  output logic [15:0] map
);

  assign map = ROT_MAP[ptype][rot];

endmodule

// File: rtl/tetris_piece_ctrl.sv
// rtl/tetris_piece_ctrl.sv - active-piece sequencer: spawn, moves, gravity, collision, lock strobe
// TETRIS_LFSR_EN: piece order from a free-running LFSR instead of the fixed 0..6 cycle.
module tetris_piece_ctrl
  import tetris_pkg::*;
#(
  parameter int         DROP_PERIOD = 25_000_000,
  parameter logic [3:0] SPAWN_X     = 4'd5,
  parameter logic [3:0] SPAWN_Y     = 4'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] occupancy,
  input  logic         game_over_in,
  input  logic         mv_left,
  input  logic         mv_right,
  input  logic         mv_rot,
  input  logic         mv_drop,
  output logic         lock_out,
  output logic [15:0]  piece_map,
  output logic [3:0]   piece_x,
  output logic [3:0]   piece_y,
  output logic         active_valid,
  output logic         busy_over
);

  localparam int             CW       = $clog2(DROP_PERIOD);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DROP_PERIOD - 1);

  state_t         state;
  piece_t         ptype;
  piece_t         spawn_type;
  logic [1:0]     rot;
  logic [CW-1:0]  grav_cnt;
  logic           grav_pend;

`ifdef TETRIS_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign spawn_type = piece_t'(3'(lfsr % 16'd7));
`else
  piece_t seq_type;

  always_ff @(posedge clk) begin
    if (!reset)                seq_type <= P_I;
    else if (state == S_SPAWN) seq_type <= next_piece(seq_type);
  end

  assign spawn_type = seq_type;
`endif

  // Coordinates are widened to 5 bits so x+dx / y+dy never wrap back onto the board.
  function automatic logic collides(input logic [15:0] map, input logic [4:0] x,
                                    input logic [4:0] y, input logic [255:0] occ);
    logic       hit;
    logic [4:0] ax, ay;
    logic [3:0] bi;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bi = 4'(15 - i);
      ax = x + 5'(i % 4);
      ay = y + 5'(i / 4);
      if (map[bi] && (ax > 5'(WALL_R) || ay > 5'd15 || occ[{ay[3:0], ax[3:0]}]))
        hit = 1'b1;
    end
    return hit;
  endfunction

  logic [15:0] spawn_map, rot_map;
  logic [4:0]  x5, y5;
  logic        hit_spawn, hit_down, hit_left, hit_right, hit_rot;
  logic        grav_tick, move_ok;

  tetris_piece_rom u_spawn_rom (.ptype(spawn_type), .rot(2'd0),        .map(spawn_map));
  tetris_piece_rom u_rot_rom   (.ptype(ptype),      .rot(rot + 2'd1),  .map(rot_map));

  assign x5        = {1'b0, piece_x};
  assign y5        = {1'b0, piece_y};
  assign hit_spawn = collides(spawn_map, {1'b0, SPAWN_X}, {1'b0, SPAWN_Y}, occupancy);
  assign hit_down  = collides(piece_map, x5, y5 + 5'd1, occupancy);
  assign hit_left  = (piece_x == 4'(WALL_L)) || collides(piece_map, x5 - 5'd1, y5, occupancy);
  assign hit_right = collides(piece_map, x5 + 5'd1, y5, occupancy);
  assign hit_rot   = collides(rot_map, x5, y5, occupancy);
  assign grav_tick = (grav_cnt == CNT_LAST);

  // Only the highest-priority request is considered; if it is rejected nothing moves.
  assign move_ok = mv_drop
                 | (mv_rot & ~hit_rot)
                 | (~mv_rot & mv_left & ~hit_left)
                 | (~mv_rot & ~mv_left & mv_right & ~hit_right);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_SPAWN;
      ptype        <= P_I;
      rot          <= 2'd0;
      piece_x      <= 4'd0;
      piece_y      <= 4'd0;
      piece_map    <= 16'h0000;
      grav_cnt     <= '0;
      grav_pend    <= 1'b0;
      lock_out     <= 1'b0;
      active_valid <= 1'b0;
      busy_over    <= 1'b0;
    end else begin
      lock_out <= 1'b0;
      case (state)
        S_SPAWN: begin
          ptype     <= spawn_type;
          rot       <= 2'd0;
          piece_x   <= SPAWN_X;
          piece_y   <= SPAWN_Y;
          piece_map <= spawn_map;
          grav_cnt  <= '0;
          grav_pend <= 1'b0;
          if (hit_spawn) begin
            state     <= S_OVER;
            busy_over <= 1'b1;
          end else begin
            state        <= S_FALL;
            active_valid <= 1'b1;
          end
        end
        S_FALL: begin
          grav_cnt <= grav_tick ? '0 : grav_cnt + 1'b1;
          if (mv_drop) begin
            state <= S_DROP;
          end else if (mv_rot) begin
            if (!hit_rot) begin
              rot       <= rot + 2'd1;
              piece_map <= rot_map;
            end
          end else if (mv_left) begin
            if (!hit_left) piece_x <= piece_x - 4'd1;
          end else if (mv_right) begin
            if (!hit_right) piece_x <= piece_x + 4'd1;
          end
          // A tick arriving while an earlier one is serviced stays pending.
          if (grav_pend && !move_ok) begin
            grav_pend <= grav_tick;
            if (!hit_down) begin
              piece_y <= piece_y + 4'd1;
            end else begin
              state    <= S_LOCK;
              lock_out <= 1'b1;
            end
          end else if (grav_tick) begin
            grav_pend <= 1'b1;
          end
        end
        S_DROP: begin
          if (!hit_down) begin
            piece_y <= piece_y + 4'd1;
          end else begin
            state    <= S_LOCK;
            lock_out <= 1'b1;
          end
        end
        S_LOCK: begin
          state        <= S_SETTLE;
          active_valid <= 1'b0;
        end
        S_SETTLE: begin
          if (game_over_in) begin
            state     <= S_OVER;
            busy_over <= 1'b1;
          end else begin
            state <= S_SPAWN;
          end
        end
        S_OVER: begin
          active_valid <= 1'b0;
          busy_over    <= 1'b1;
        end
        default: state <= S_SPAWN;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// tb/tb_tetris_piece_ctrl.sv - vector table, directed corner sequences and random run vs reference model
module tb_tetris_piece_ctrl;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] occupancy;
  logic         game_over_in, mv_left, mv_right, mv_rot, mv_drop;
  logic         lock_out;
  logic [15:0]  piece_map;
  logic [3:0]   piece_x, piece_y;
  logic         active_valid, busy_over;

  int total = 0;
  int bad   = 0;
  bit use_model = 0;
  bit board [16][16];

  localparam logic [15:0] SHAPES [0:6][0:3] = '{
    '{16'h00F0, 16'h2222, 16'h0F00, 16'h4444},
    '{16'h6600, 16'h6600, 16'h6600, 16'h6600},
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80},
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440}
  };

  tetris_piece_ctrl #(.DROP_PERIOD(P), .SPAWN_X(4'd5), .SPAWN_Y(4'd0)) dut (
    .clk(clk), .reset(reset), .occupancy(occupancy), .game_over_in(game_over_in),
    .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot), .mv_drop(mv_drop),
    .lock_out(lock_out), .piece_map(piece_map), .piece_x(piece_x), .piece_y(piece_y),
    .active_valid(active_valid), .busy_over(busy_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: phase 0 spawn, 1 fall, 2 drop, 3 lock, 4 settle, 5 over.
  int m_phase, m_type, m_rot, m_x, m_y, m_tick, m_next;
  bit m_pend, m_fresh;

  function automatic bit fits(input int t, input int r, input int x, input int y);
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        if (SHAPES[t][r][15 - (row * 4 + col)]) begin
          if (x + col > 11 || y + row > 15) return 0;
          if (board[y + row][x + col]) return 0;
        end
    return 1;
  endfunction

  task automatic model_step();
    bit acc, term;
    if (!reset) begin
      m_phase = 0; m_type = 0; m_rot = 0; m_x = 0; m_y = 0;
      m_tick = 0; m_next = 0; m_pend = 0; m_fresh = 1;
      return;
    end
    case (m_phase)
      0: begin
        m_type = m_next; m_next = (m_next + 1) % 7;
        m_rot = 0; m_x = 5; m_y = 0; m_tick = 0; m_pend = 0; m_fresh = 0;
        m_phase = fits(m_type, 0, 5, 0) ? 1 : 5;
      end
      1: begin
        acc = 0;
        if (mv_drop) begin
          m_phase = 2; acc = 1;
        end else if (mv_rot) begin
          if (fits(m_type, (m_rot + 1) % 4, m_x, m_y)) begin m_rot = (m_rot + 1) % 4; acc = 1; end
        end else if (mv_left) begin
          if (m_x > 0 && fits(m_type, m_rot, m_x - 1, m_y)) begin m_x--; acc = 1; end
        end else if (mv_right) begin
          if (fits(m_type, m_rot, m_x + 1, m_y)) begin m_x++; acc = 1; end
        end
        term = (m_tick == P - 1);
        m_tick = (m_tick + 1) % P;
        if (m_pend && !acc) begin
          m_pend = 0;
          if (fits(m_type, m_rot, m_x, m_y + 1)) m_y++;
          else m_phase = 3;
        end
        if (term) m_pend = 1;
      end
      2: if (fits(m_type, m_rot, m_x, m_y + 1)) m_y++; else m_phase = 3;
      3: m_phase = 4;
      4: m_phase = game_over_in ? 5 : 0;
      default: ;
    endcase
  endtask

  function automatic logic [26:0] model_outs();
    logic [15:0] m;
    m = m_fresh ? 16'h0000 : SHAPES[m_type][m_rot];
    return {m_phase == 3, m, 4'(m_x), 4'(m_y), (m_phase >= 1 && m_phase <= 3), m_phase == 5};
  endfunction

  function automatic logic [26:0] outs();
    return {lock_out, piece_map, piece_x, piece_y, active_valid, busy_over};
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    @(negedge clk);
    if (use_model) check("model", outs(), model_outs());
  endtask

  task automatic drive(input bit r, input bit d, input bit rt, input bit l, input bit rr);
    reset = r; mv_drop = d; mv_rot = rt; mv_left = l; mv_right = rr;
  endtask

  task automatic set_board(input bit scatter);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        board[r][c] = (c == 0 || c == 11) ||
                      (scatter && r >= 6 && c >= 1 && c <= 10 && $urandom_range(4) == 0);
        occupancy[r * 16 + c] = board[r][c];
      end
  endtask

  typedef struct {
    bit          rst, d, rt, l, r;
    logic [15:0] map;
    logic [3:0]  x, y;
    bit          v, ov, lk;
  } vec_t;

  vec_t tbl [8];
  int   ticks;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 16'h0000, 4'd0, 4'd0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 16'h00F0, 4'd5, 4'd0, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 0, 16'h00F0, 4'd4, 4'd0, 1, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 0, 16'h00F0, 4'd3, 4'd0, 1, 0, 0};
    tbl[4] = '{1, 0, 0, 1, 0, 16'h00F0, 4'd2, 4'd0, 1, 0, 0};
    tbl[5] = '{1, 0, 0, 1, 0, 16'h00F0, 4'd1, 4'd0, 1, 0, 0};
    tbl[6] = '{1, 0, 0, 1, 0, 16'h00F0, 4'd1, 4'd1, 1, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 16'h00F0, 4'd1, 4'd1, 1, 0, 0};

    game_over_in = 0;
    drive(0, 0, 0, 0, 0);
    set_board(0);
    tick();
    tick();

    // Reset state, spawn of I, four accepted lefts, fifth blocked by the wall column.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].d, tbl[i].rt, tbl[i].l, tbl[i].r);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].lk, tbl[i].map, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].ov});
    end

    // Idle gravity: I (row 2 of its map) can rest no lower than y=13.
    drive(1, 0, 0, 0, 0);
    ticks = 0;
    while (!lock_out && ticks < 100) begin
      tick();
      ticks++;
    end
    check("grav_ticks", 27'(ticks), 27'd51);
    check("grav_lock", outs(), {1'b1, 16'h00F0, 4'd1, 4'd13, 1'b1, 1'b0});
    tick();
    check("settle", outs(), {1'b0, 16'h00F0, 4'd1, 4'd13, 1'b0, 1'b0});
    tick();
    tick();
    check("spawn_o", outs(), {1'b0, 16'h6600, 4'd5, 4'd0, 1'b1, 1'b0});

    // Hard drop with all other requests held high during the drop.
    drive(1, 1, 0, 0, 0);
    tick();
    check("drop_start", outs(), {1'b0, 16'h6600, 4'd5, 4'd0, 1'b1, 1'b0});
    drive(1, 0, 1, 1, 1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      check($sformatf("drop_y%0d", i), outs(), {1'b0, 16'h6600, 4'd5, 4'(i), 1'b1, 1'b0});
    end
    tick();
    check("drop_lock", outs(), {1'b1, 16'h6600, 4'd5, 4'd14, 1'b1, 1'b0});
    drive(1, 0, 0, 0, 0);
    game_over_in = 1;
    tick();
    check("go_settle", outs(), {1'b0, 16'h6600, 4'd5, 4'd14, 1'b0, 1'b0});
    tick();
    check("go_over", outs(), {1'b0, 16'h6600, 4'd5, 4'd14, 1'b0, 1'b1});

    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
      game_over_in = $urandom_range(1);
      tick();
      check("over_hold", 27'({lock_out, active_valid, busy_over}), 27'b001);
    end

    drive(0, 0, 0, 0, 0);
    game_over_in = 0;
    tick();
    check("over_reset", outs(), 27'd0);
    drive(1, 0, 0, 0, 0);
    tick();
    check("respawn_i", outs(), {1'b0, 16'h00F0, 4'd5, 4'd0, 1'b1, 1'b0});

    // Randomized episodes on scattered boards against the reference model.
    use_model = 1;
    for (int ep = 0; ep < 4; ep++) begin
      drive(0, 0, 0, 0, 0);
      set_board(1);
      tick();
      for (int c = 0; c < 700; c++) begin
        drive($urandom_range(149) != 0,
              $urandom_range(39) == 0,
              $urandom_range(5) == 0,
              $urandom_range(5) == 0,
              $urandom_range(5) == 0);
        game_over_in = ($urandom_range(9) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
